// File: rtl/master_top.sv
// Epoch-sequenced swap master: grants vertex moves against the pairwise swap budget
// and steers granted vertex IDs onto per-bank vertex-ID SRAM write ports.
module master_top #(
  parameter int N         = 4096,
  parameter int K         = 16,
  parameter int Q         = 16,
  parameter int NEXT_BW   = 4,
  parameter int PRO_BW    = 8,
  parameter int VID_BW    = 12,
  parameter int MAX_EPOCH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NEXT_BW*Q-1:0]  in_next_arr,
  input  logic [PRO_BW*K-1:0]   in_mi_j,
  input  logic [PRO_BW*K-1:0]   in_mj_i,
  input  logic [VID_BW*Q-1:0]   in_v_gidx,
  input  logic [PRO_BW*Q-1:0]   in_proposal_nums,
  output logic [7:0]            epoch,
  output logic [K-1:0]          vidsram_wen,
  output logic                  ready,
  output logic                  finish
);

  localparam logic [8:0] CNT_MAX = 9'(MAX_EPOCH + 4);
  localparam logic [8:0] RDY_LO  = 9'd4;
  localparam logic [8:0] RDY_HI  = 9'(MAX_EPOCH + 3);

  logic [8:0]           cnt_r;
  logic [8:0]           cnt_nxt_s;
  logic [7:0]           epoch_r;
  logic                 ready_r;
  logic                 finish_r;
  logic [Q-1:0]         grant_s;
  logic [Q-1:0]         grant1_r, grant2_r, grant3_r;
  logic [NEXT_BW*Q-1:0] next1_r, next2_r, next3_r;
  logic [K-1:0]         wen_s;
  logic [VID_BW*Q-1:0]  vidsram_wdata [0:K-1];

  // Next cycle count: advance only when enabled, saturating at the end of the run.
  always_comb begin
    cnt_nxt_s = (enable && (cnt_r != CNT_MAX)) ? cnt_r + 9'd1 : cnt_r;
  end

  // Stage 1: a vertex is granted when its rank is below the smaller of the two budgets.
  always_comb begin
    grant_s = '0;
    for (int q = 0; q < Q; q++) begin
      logic [NEXT_BW-1:0] t;
      logic [PRO_BW-1:0]  mi, mj, lim, rank;
      t    = in_next_arr[NEXT_BW*(Q-q)-1 -: NEXT_BW];
      mi   = in_mi_j[PRO_BW*(K-int'(t))-1 -: PRO_BW];
      mj   = in_mj_i[PRO_BW*(K-int'(t))-1 -: PRO_BW];
      rank = in_proposal_nums[PRO_BW*(Q-q)-1 -: PRO_BW];
      lim  = (mi < mj) ? mi : mj;
      grant_s[q] = (rank < lim);
    end
  end

  // Counter, status registers and the 3-deep grant/target pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 9'd0;
      epoch_r  <= 8'd0;
      ready_r  <= 1'b0;
      finish_r <= 1'b0;
      grant1_r <= '0;
      grant2_r <= '0;
      grant3_r <= '0;
      next1_r  <= '0;
      next2_r  <= '0;
      next3_r  <= '0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      epoch_r  <= (cnt_nxt_s > 9'd255) ? 8'd255 : cnt_nxt_s[7:0];
      ready_r  <= (cnt_nxt_s >= RDY_LO) && (cnt_nxt_s <= RDY_HI);
      finish_r <= finish_r | (cnt_nxt_s == CNT_MAX);
      // Pipeline stalls together with the counter so epochs stay aligned.
      if (enable) begin
        grant1_r <= grant_s;
        grant2_r <= grant1_r;
        grant3_r <= grant2_r;
        next1_r  <= in_next_arr;
        next2_r  <= next1_r;
        next3_r  <= next2_r;
      end
    end
  end

  // Output steering: slot q of the target bank carries the live vertex ID when granted.
  always_comb begin
    wen_s = '0;
    for (int b = 0; b < K; b++) begin
      vidsram_wdata[b] = '0;
    end
    for (int q = 0; q < Q; q++) begin
      logic [NEXT_BW-1:0] t;
      logic               hit;
      t   = next3_r[NEXT_BW*(Q-q)-1 -: NEXT_BW];
      hit = ready_r & grant3_r[q];
      wen_s[K-1-int'(t)] = wen_s[K-1-int'(t)] | hit;
      vidsram_wdata[t][VID_BW*(Q-q)-1 -: VID_BW] =
        hit ? in_v_gidx[VID_BW*(Q-q)-1 -: VID_BW] : {VID_BW{1'b0}};
    end
  end

  assign epoch       = epoch_r;
  assign ready       = ready_r;
  assign finish      = finish_r;
  assign vidsram_wen = wen_s;

endmodule

// File: tb/tb_master_top.sv
// Directed bench for master_top: epoch sequencing, grant budget, stall and mid-run reset.
module tb_master_top;

  localparam int K = 16;
  localparam int Q = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [63:0]   in_next_arr;
  logic [127:0]  in_mi_j;
  logic [127:0]  in_mj_i;
  logic [191:0]  in_v_gidx;
  logic [127:0]  in_proposal_nums;
  logic [7:0]    epoch;
  logic [15:0]   vidsram_wen;
  logic          ready;
  logic          finish;

  int total = 0;
  int bad   = 0;
  int bcnt  = 0;

  master_top dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_next_arr(in_next_arr), .in_mi_j(in_mi_j), .in_mj_i(in_mj_i),
    .in_v_gidx(in_v_gidx), .in_proposal_nums(in_proposal_nums),
    .epoch(epoch), .vidsram_wen(vidsram_wen), .ready(ready), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Proposal-side inputs for epoch e, and the vertex IDs of epoch e4.
  task automatic drive(input int e, input int e4);
    in_next_arr = 64'h0; in_proposal_nums = 128'h0;
    in_mi_j = {16{8'hFF}}; in_mj_i = {16{8'hFF}};
    if (e == 0) begin
      in_next_arr = 64'h0123456789ABCDEF;
      in_mi_j = {16{8'h01}}; in_mj_i = {16{8'h01}};
    end else if (e == 1) begin
      in_next_arr = {16{4'h3}};
      for (int q = 0; q < Q; q++) in_proposal_nums[8*(Q-q)-1 -: 8] = 8'(q);
      in_mi_j = {16{8'h05}}; in_mj_i = {16{8'h09}};
    end else if (e == 2) begin
      in_next_arr = {16{4'h2}};
      in_mi_j = {16{8'h00}}; in_mj_i = {16{8'hFF}};
    end else if (e > 2 && e < 256) begin
      for (int q = 0; q < Q; q++) in_next_arr[4*(Q-q)-1 -: 4] = 4'(e % 16);
      in_mi_j = {16{8'h01}}; in_mj_i = {16{8'h01}};
    end
    in_v_gidx = {16{12'hFFF}};
    if (e4 >= 0 && e4 < 256)
      for (int q = 0; q < Q; q++) in_v_gidx[12*(Q-q)-1 -: 12] = 12'(e4 * 16 + q);
  endtask

  function automatic logic [15:0] exp_wen(input int e);
    if (e == 0)      return 16'hFFFF;
    else if (e == 1) return 16'h1000;
    else if (e == 2) return 16'h0000;
    else             return 16'h8000 >> (e % 16);
  endfunction

  function automatic logic [191:0] exp_wdata(input int e, input int b);
    logic [191:0] v;
    v = '0;
    if (e == 0) v[12*(Q-b)-1 -: 12] = 12'(b);
    else if (e == 1 && b == 3)
      for (int q = 0; q < 5; q++) v[12*(Q-q)-1 -: 12] = 12'(16 + q);
    else if (e == 20 && b == 4)
      for (int q = 0; q < Q; q++) v[12*(Q-q)-1 -: 12] = 12'(320 + q);
    return v;
  endfunction

  task automatic check_all();
    int  e4;
    logic rdy;
    e4  = bcnt - 4;
    rdy = (bcnt >= 4) && (bcnt <= 259);
    chk($sformatf("epoch@%0d", bcnt), 192'(epoch), 192'((bcnt > 255) ? 255 : bcnt));
    chk($sformatf("ready@%0d", bcnt), 192'(ready), 192'(rdy));
    chk($sformatf("finish@%0d", bcnt), 192'(finish), 192'(bcnt == 260));
    chk($sformatf("wen@%0d", bcnt), 192'(vidsram_wen), 192'(rdy ? exp_wen(e4) : 16'h0));
    if (!rdy || e4 == 0 || e4 == 1 || e4 == 2 || e4 == 20)
      for (int b = 0; b < K; b++)
        chk($sformatf("wdata%0d@%0d", b, bcnt), dut.vidsram_wdata[b],
            rdy ? exp_wdata(e4, b) : 192'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (enable && bcnt != 260) bcnt++;
    drive(bcnt - 1, bcnt - 4);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; bcnt = 0;
    drive(-1, -4);
    #2 check_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_all();

    while (bcnt < 30) step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    while (bcnt < 100) step();

    // Asynchronous abort mid-run, then a full replay.
    rst_n = 1'b0;
    #1 bcnt = 0;
    drive(-1, -4);
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    rst_n = 1'b1;
    while (bcnt < 260) step();
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/master_top.md
Name: master_top

Overview:
- Epoch-sequenced master for the graph-partition swap engine.
- Each epoch covers Q=16 vertices, and each vertex proposes a move to one of K=16 partition banks.
- The block grants a move only when the pairwise swap budget allows it.
- Granted vertex IDs go to per-bank vertex-ID SRAM write ports. There are 256 epochs (4096 vertices); after the last epoch the block raises finish.

Parameters:
- N, 4096, total vertices
- K, 16, partitions/banks
- Q, 16, vertices per epoch
- NEXT_BW, 4, bank index width
- PRO_BW, 8, proposal count width
- VID_BW, 12, vertex ID width
- MAX_EPOCH, 256, epochs per run (N/Q)

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  advances the cycle counter when high; all state holds when low
- in_next_arr  in  NEXT_BW*Q  target bank per vertex
- in_mi_j  in  PRO_BW*K  proposals from the current partition to bank j
- in_mj_i  in  PRO_BW*K  proposals from bank j to the current partition
- in_v_gidx  in  VID_BW*Q  global vertex ID per vertex
- in_proposal_nums  in  PRO_BW*Q  rank of this vertex's proposal toward its target
- epoch  out  8  current input epoch counter
- vidsram_wen  out  K  per-bank write enable; bank 0 at MSB
- ready  out  1  output window valid
- finish  out  1  run complete

Behaviour:
- Packing: all packed vectors hold element 0 at the MSB. Element i of width W occupies bits [W*(n-i)-1 : W*(n-i-1)], where n is the element count.
- Internal cycle counter cnt, 9 bits or more:
  - Reset value 0.
  - Increments by 1 on each posedge with enable=1.
  - Saturates at 260.
- epoch = min(cnt, 255).
- Input timing for epoch n:
  - in_next_arr, in_mi_j, in_mj_i and in_proposal_nums are valid while cnt=n+1.
  - in_v_gidx is valid while cnt=n+4, i.e. 3 cycles later.
- Stage 1, combinational on the cnt=n+1 inputs. For each q:
  - t = next[q]
  - grant[q] = proposal_nums[q] < min(mi_j[t], mj_i[t]), compared as 8-bit unsigned.
- Pipeline: grant[Q] and next[Q] are registered at the end of cnt=n+1, then shifted through a 3-deep register pipeline. At cnt=n+4 the stage-3 entry belongs to epoch n.
- Output at cnt=n+4, combinational from the stage-3 registers and the live in_v_gidx:
  - vidsram_wen bit for bank b = OR over q of (grant[q] && next[q]==b).
  - The internal signal vidsram_wdata is an array [0:K-1] of VID_BW*Q bits. The bench probes it hierarchically, so it must exist under exactly this name.
  - Slot q of vidsram_wdata[b] = in_v_gidx[q] if grant[q] && next[q]==b, else 0. Positional, no compaction.
- ready:
  - Registered.
  - 1 exactly while 4 <= cnt <= 259, i.e. exactly 256 consecutive cycles, epochs 0..255.
  - 0 otherwise.
- Outside the ready window: vidsram_wen = 0 and vidsram_wdata is all zero.
- finish: registered, 1 when cnt==260, holds until reset.
- Reset (async): cnt, all pipeline registers, ready and finish clear to 0. epoch=0, vidsram_wen=0.
- Reset mid-run aborts the run. After release the sequence restarts from cnt=0.
- enable low stalls cnt and the pipeline together. Outputs keep their pipeline alignment.
- No handshake beyond ready; the downstream writer samples every cycle ready=1.

Test Plan:
- Reset with enable=1, then release → epoch steps 0,1,2..., saturates at 255. ready rises when cnt=4, falls after 256 cycles. finish=1 at cnt=260 and stays high.
- Epoch 0 inputs:
  - next=0x0123456789ABCDEF
  - proposal_nums all 0x00
  - mi_j and mj_i all 0x01
  - v_gidx = IDs 0..15
  → at cnt=4: vidsram_wen=0xFFFF; vidsram_wdata[b] holds ID b in slot b, zeros elsewhere.
- Budget limit, all vertices target bank 3:
  - proposal_nums = 0..15
  - mi_j[3]=5, mj_i[3]=9
  → only q=0..4 granted. vidsram_wen=0x1000. vidsram_wdata[3] has slots 0..4 filled, slots 5..15 zero.
- mi_j[t]=0 for every target → vidsram_wen=0x0000 and all wdata zero for that epoch.
- enable deasserted 3 cycles mid-run → epoch, ready and outputs freeze. On resume the wen sequence continues with no skipped or duplicated epoch.
- rst_n pulsed low at cnt=100 → outputs clear immediately. The full 256-epoch sequence then replays correctly.
